// File: rtl/md_seq_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: opcode/funct
// constants and the internal operation code carried from decode to the datapath.
package md_seq_unit_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [5:0] FN_MADD  = 6'h00;
  localparam logic [5:0] FN_MADDU = 6'h01;
  localparam logic [5:0] FN_MSUB  = 6'h04;
  localparam logic [5:0] FN_MSUBU = 6'h05;

  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MADDU = 3'd5,
    MD_MSUB  = 3'd6,
    MD_MSUBU = 3'd7
  } mdop_e;

  function automatic logic mdop_signed(input mdop_e op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

  function automatic logic mdop_is_div(input mdop_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_seq_unit_decode.sv
// Combinational decoder for the HI/LO instruction class; used for both the
// E-stage (valid-qualified) and D-stage (valid tied high) instructions.
module md_decode
  import md_seq_unit_pkg::*;
#(
  parameter bit MACC_EN = 1'b1
) (
  input  logic [31:0] instr,
  input  logic        valid,
  output mdop_e       mdop,
  output logic        start,
  output logic        usemd,
  output logic        is_mthi,
  output logic        is_mtlo,
  output logic        is_mfhi,
  output logic        is_mflo
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       special;
  logic       special2;
  logic       base_op;
  logic       acc_op;
  logic       unused_fields;

  assign op            = instr[31:26];
  assign fn            = instr[5:0];
  assign unused_fields = ^instr[25:6];
  assign special       = (op == OP_SPECIAL);
  assign special2      = (op == OP_SPECIAL2) && MACC_EN;

  always_comb begin
    mdop    = MD_MULT;
    base_op = 1'b0;
    acc_op  = 1'b0;
    if (special) begin
      case (fn)
        FN_MULT:  begin mdop = MD_MULT;  base_op = 1'b1; end
        FN_MULTU: begin mdop = MD_MULTU; base_op = 1'b1; end
        FN_DIV:   begin mdop = MD_DIV;   base_op = 1'b1; end
        FN_DIVU:  begin mdop = MD_DIVU;  base_op = 1'b1; end
        default:  ;
      endcase
    end else if (special2) begin
      case (fn)
        FN_MADD:  begin mdop = MD_MADD;  acc_op = 1'b1; end
        FN_MADDU: begin mdop = MD_MADDU; acc_op = 1'b1; end
        FN_MSUB:  begin mdop = MD_MSUB;  acc_op = 1'b1; end
        FN_MSUBU: begin mdop = MD_MSUBU; acc_op = 1'b1; end
        default:  ;
      endcase
    end
  end

  assign is_mfhi = valid && special && (fn == FN_MFHI);
  assign is_mthi = valid && special && (fn == FN_MTHI);
  assign is_mflo = valid && special && (fn == FN_MFLO);
  assign is_mtlo = valid && special && (fn == FN_MTLO);
  assign start   = valid && (base_op || acc_op);
  assign usemd   = is_mfhi || is_mthi || is_mflo || is_mtlo || start;

endmodule

// File: rtl/md_seq_unit.sv
// Execute-stage multiply/divide sequencer: computes the result at accept time,
// holds it in a pending register and commits it to HI/LO when the busy counter expires.
module md_seq_unit
  import md_seq_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter bit MACC_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_e,
  input  logic             valid_e,
  input  logic [31:0]      instr_d,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] md_rdata,
  output logic             busy,
  output logic             stall_d
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdop_e e_mdop;
  logic  e_start, e_mthi, e_mtlo, e_mfhi, e_mflo, e_usemd_unused;
  mdop_e d_mdop_unused;
  logic  d_usemd, d_start_unused;
  logic  d_mthi_unused, d_mtlo_unused, d_mfhi_unused, d_mflo_unused;

  md_decode #(.MACC_EN(MACC_EN)) u_dec_e (
    .instr   (instr_e),
    .valid   (valid_e),
    .mdop    (e_mdop),
    .start   (e_start),
    .usemd   (e_usemd_unused),
    .is_mthi (e_mthi),
    .is_mtlo (e_mtlo),
    .is_mfhi (e_mfhi),
    .is_mflo (e_mflo)
  );

  md_decode #(.MACC_EN(MACC_EN)) u_dec_d (
    .instr   (instr_d),
    .valid   (1'b1),
    .mdop    (d_mdop_unused),
    .start   (d_start_unused),
    .usemd   (d_usemd),
    .is_mthi (d_mthi_unused),
    .is_mtlo (d_mtlo_unused),
    .is_mfhi (d_mfhi_unused),
    .is_mflo (d_mflo_unused)
  );

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] pending_q, pending_d;

  logic               sgn;
  logic [2*WIDTH-1:0] mul_a, mul_b, product, acc, result;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b, div_b, quo_u, rem_u, quo, rem;

  assign sgn = mdop_signed(e_mdop);
  assign acc = {hi_q, lo_q};

  // Sign-extending to 2*WIDTH lets one truncated multiply serve both signednesses.
  assign mul_a   = {{WIDTH{sgn & rs_val[WIDTH-1]}}, rs_val};
  assign mul_b   = {{WIDTH{sgn & rt_val[WIDTH-1]}}, rt_val};
  assign product = mul_a * mul_b;

  // Signed divide via magnitudes; the most-negative / -1 case wraps to itself naturally.
  assign neg_a = sgn & rs_val[WIDTH-1];
  assign neg_b = sgn & rt_val[WIDTH-1];
  assign abs_a = neg_a ? -rs_val : rs_val;
  assign abs_b = neg_b ? -rt_val : rt_val;
  assign div_b = (rt_val == '0) ? WIDTH'(1) : abs_b;
  assign quo_u = abs_a / div_b;
  assign rem_u = abs_a % div_b;
  assign quo   = (neg_a ^ neg_b) ? -quo_u : quo_u;
  assign rem   = neg_a ? -rem_u : rem_u;

  always_comb begin
    result = product;
    case (e_mdop)
      MD_MADD, MD_MADDU: result = acc + product;
      MD_MSUB, MD_MSUBU: result = acc - product;
      MD_DIV, MD_DIVU:   result = (rt_val == '0) ? acc : {rem, quo};
      default:           result = product;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pending_d = pending_q;
    if (busy) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        {hi_d, lo_d} = pending_q;
      end
    end else begin
      if (e_start) begin
        pending_d = result;
        cnt_d     = mdop_is_div(e_mdop) ? DIV_CNT : MULT_CNT;
      end
      if (e_mthi) hi_d = rs_val;
      if (e_mtlo) lo_d = rs_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pending_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pending_q <= pending_d;
    end
  end

  assign busy     = (cnt_q != '0);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_rdata = e_mfhi ? hi_q : (e_mflo ? lo_q : '0);
  assign stall_d  = d_usemd && (busy || e_start);

endmodule

// File: tb/tb_md_seq_unit.sv
// Directed bench for md_seq_unit: table of HI/LO ops with hand-computed results,
// plus sequences for mid-op reset, mthi-while-busy and a MACC_EN=0 build.
module tb_md_seq_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_e = '0, instr_d = '0, rs_val = '0, rt_val = '0;
  logic        valid_e = 1'b0;
  logic [31:0] hi, lo, md_rdata;
  logic        busy, stall_d;

  logic [31:0] instr_e0 = '0, instr_d0 = '0, rs0 = '0, rt0 = '0;
  logic        valid_e0 = 1'b0;
  logic [31:0] hi0, lo0, md_rdata0;
  logic        busy0, stall_d0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  md_seq_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .MACC_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .instr_e(instr_e), .valid_e(valid_e), .instr_d(instr_d),
    .rs_val(rs_val), .rt_val(rt_val), .hi(hi), .lo(lo), .md_rdata(md_rdata),
    .busy(busy), .stall_d(stall_d)
  );

  md_seq_unit #(.WIDTH(32), .MULT_CYCLES(3), .DIV_CYCLES(4), .MACC_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .instr_e(instr_e0), .valid_e(valid_e0), .instr_d(instr_d0),
    .rs_val(rs0), .rt_val(rt0), .hi(hi0), .lo(lo0), .md_rdata(md_rdata0),
    .busy(busy0), .stall_d(stall_d0)
  );

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [5:0] fn);
    return {op, 5'd4, 5'd5, 5'd2, 5'd0, fn};
  endfunction

  localparam logic [5:0] SP = 6'h00, SP2 = 6'h1C;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    int          cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev_hi, prev_lo;
    int n;

    vecs[0]  = '{"mult -2*3",     enc(SP, 6'h18),  32'hFFFFFFFE, 32'h3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"divu 100/7",    enc(SP, 6'h1B),  32'd100,      32'd7,        10, 32'd2,        32'd14};
    vecs[2]  = '{"div -7/2",      enc(SP, 6'h1A),  32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"multu max*max", enc(SP, 6'h19),  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[4]  = '{"div overflow",  enc(SP, 6'h1A),  32'h80000000, 32'hFFFFFFFF, 10, 32'h0,        32'h80000000};
    vecs[5]  = '{"mthi 11",       enc(SP, 6'h11),  32'h11,       32'h0,        0,  32'h11,       32'h80000000};
    vecs[6]  = '{"mtlo 22",       enc(SP, 6'h13),  32'h22,       32'h0,        0,  32'h11,       32'h22};
    vecs[7]  = '{"div by zero",   enc(SP, 6'h1A),  32'd5,        32'd0,        10, 32'h11,       32'h22};
    vecs[8]  = '{"mthi 1234",     enc(SP, 6'h11),  32'h1234,     32'h0,        0,  32'h1234,     32'h22};
    vecs[9]  = '{"mtlo 5678",     enc(SP, 6'h13),  32'h5678,     32'h0,        0,  32'h1234,     32'h5678};
    vecs[10] = '{"madd 2*3",      enc(SP2, 6'h00), 32'd2,        32'd3,        5,  32'h1234,     32'h567E};
    vecs[11] = '{"msubu 1*567F",  enc(SP2, 6'h05), 32'd1,        32'h567F,     5,  32'h1233,     32'hFFFFFFFF};
    vecs[12] = '{"maddu max*2",   enc(SP2, 6'h01), 32'hFFFFFFFF, 32'd2,        5,  32'h1235,     32'hFFFFFFFD};
    vecs[13] = '{"msub -1*3",     enc(SP2, 6'h04), 32'hFFFFFFFF, 32'd3,        5,  32'h1236,     32'h0};
    vecs[14] = '{"div 7/-2",      enc(SP, 6'h1A),  32'd7,        32'hFFFFFFFE, 10, 32'h1,        32'hFFFFFFFD};
    vecs[15] = '{"mult 2^16sq",   enc(SP, 6'h18),  32'h10000,    32'h10000,    5,  32'h1,        32'h0};

    // Reset state
    #3;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst stall_d", 64'(stall_d), 64'd0);
    step();
    step();
    reset = 1'b1;
    step();

    prev_hi = 32'h0;
    prev_lo = 32'h0;
    for (int i = 0; i < 16; i++) begin
      instr_d = enc(SP, 6'h12);
      instr_e = vecs[i].instr;
      rs_val  = vecs[i].rs;
      rt_val  = vecs[i].rt;
      valid_e = 1'b1;
      #1;
      if (vecs[i].cycles > 0) chk({vecs[i].name, " stall@issue"}, 64'(stall_d), 64'd1);
      step();
      valid_e = 1'b0;
      instr_e = '0;
      #1;
      if (vecs[i].cycles > 0) begin
        chk({vecs[i].name, " hi not early"}, 64'(hi), 64'(prev_hi));
        chk({vecs[i].name, " lo not early"}, 64'(lo), 64'(prev_lo));
        n = 0;
        while (busy && n < 100) begin
          if (stall_d !== 1'b1) chk({vecs[i].name, " stall during busy"}, 64'(stall_d), 64'd1);
          n++;
          step();
        end
        chk({vecs[i].name, " busy cycles"}, 64'(n), 64'(vecs[i].cycles));
        chk({vecs[i].name, " stall released"}, 64'(stall_d), 64'd0);
      end
      chk({vecs[i].name, " hi"}, 64'(hi), 64'(vecs[i].exp_hi));
      chk({vecs[i].name, " lo"}, 64'(lo), 64'(vecs[i].exp_lo));
      prev_hi = vecs[i].exp_hi;
      prev_lo = vecs[i].exp_lo;
    end

    // mfhi / mflo read path
    instr_e = enc(SP, 6'h10); valid_e = 1'b1; #1;
    chk("mfhi rdata", 64'(md_rdata), 64'h1);
    instr_e = enc(SP, 6'h12); #1;
    chk("mflo rdata", 64'(md_rdata), 64'h0);
    chk("mflo no start", 64'(stall_d), 64'd0);
    valid_e = 1'b0; #1;
    chk("rdata invalid", 64'(md_rdata), 64'h0);
    step();

    // mthi while busy is ignored
    instr_e = enc(SP, 6'h18); rs_val = 32'd2; rt_val = 32'd2; valid_e = 1'b1;
    step();
    instr_e = enc(SP, 6'h11); rs_val = 32'h99;
    step();
    valid_e = 1'b0; instr_e = '0;
    repeat (6) step();
    chk("mthi busy hi", 64'(hi), 64'h0);
    chk("mthi busy lo", 64'(lo), 64'h4);

    // Asynchronous reset in the middle of a divide
    instr_d = enc(SP, 6'h12);
    instr_e = enc(SP, 6'h1B); rs_val = 32'd100; rt_val = 32'd7; valid_e = 1'b1;
    step();
    valid_e = 1'b0; instr_e = '0;
    step();
    step();
    #2 reset = 1'b0;
    #1;
    chk("midop rst busy", 64'(busy), 64'd0);
    chk("midop rst hi", 64'(hi), 64'd0);
    chk("midop rst lo", 64'(lo), 64'd0);
    chk("midop rst stall", 64'(stall_d), 64'd0);
    step();
    step();
    reset = 1'b1;
    repeat (12) step();
    chk("post rst busy", 64'(busy), 64'd0);
    chk("post rst hi", 64'(hi), 64'd0);
    chk("post rst lo", 64'(lo), 64'd0);

    // MACC_EN=0 build
    instr_e0 = enc(SP, 6'h11); rs0 = 32'h55; valid_e0 = 1'b1;
    step();
    chk("m0 mthi", 64'(hi0), 64'h55);
    instr_e0 = enc(SP2, 6'h00); rs0 = 32'd2; rt0 = 32'd3;
    instr_d0 = enc(SP2, 6'h00);
    #1;
    chk("m0 madd stall_d", 64'(stall_d0), 64'd0);
    step();
    valid_e0 = 1'b0; instr_e0 = '0;
    #1;
    chk("m0 madd busy", 64'(busy0), 64'd0);
    repeat (4) step();
    chk("m0 madd hi", 64'(hi0), 64'h55);
    chk("m0 madd lo", 64'(lo0), 64'h0);
    instr_e0 = enc(SP, 6'h18); rs0 = 32'd6; rt0 = 32'd7; valid_e0 = 1'b0;
    instr_d0 = enc(SP, 6'h12);
    #1;
    chk("m0 invalid stall", 64'(stall_d0), 64'd0);
    step();
    chk("m0 invalid busy", 64'(busy0), 64'd0);
    valid_e0 = 1'b1;
    step();
    valid_e0 = 1'b0; instr_e0 = '0;
    #1;
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      step();
    end
    chk("m0 mult cycles", 64'(n), 64'd3);
    chk("m0 mult lo", 64'(lo0), 64'd42);
    chk("m0 mult hi", 64'(hi0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/md_seq_unit.md
Name: md_seq_unit

Overview:
- Parametrised multiply/divide sequencer with HI/LO register pair, in the execute stage of the 5-stage MIPS pipeline.
- Decodes SPECIAL mult/multu/div/divu/mfhi/mflo/mthi/mtlo and SPECIAL2 madd/maddu/msub/msubu directly from the E-stage instruction.
- Models configurable op latency with a busy counter.
- Produces the D-stage stall request for any HI/LO-class instruction while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu; range 1..63.
- DIV_CYCLES, 10, busy cycles for div/divu; range 1..63.
- MACC_EN, 1, enables the SPECIAL2 accumulate ops; when 0 they decode as no-ops.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_e  in  32  instruction in E stage.
- valid_e  in  1  E-stage instruction is real (0 = bubble/flushed).
- instr_d  in  32  instruction in D stage, used for stall generation only.
- rs_val  in  WIDTH  forwarded rs operand.
- rt_val  in  WIDTH  forwarded rt operand.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- md_rdata  out  WIDTH  hi for mfhi, lo for mflo, else 0 (combinational).
- busy  out  1  operation in flight.
- stall_d  out  1  hold D stage.

Behaviour:
- Decode:
  - SPECIAL op=0x00; funct mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13, mult 0x18, multu 0x19, div 0x1A, divu 0x1B.
  - SPECIAL2 op=0x1C; funct madd 0x00, maddu 0x01, msub 0x04, msubu 0x05.
  - All decode is qualified by valid_e.
- start_e = valid_e and (mult/multu/div/divu, or accumulate op with MACC_EN=1).
- Start accept, at the edge where start_e=1 and busy=0:
  - Latch the result into a 2*WIDTH pending register.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
- Busy behaviour:
  - busy = (cnt != 0).
  - cnt decrements each edge while nonzero.
  - On the edge where cnt goes 1->0, {hi,lo} <= pending, and busy falls in that same cycle.
  - Net latency: new HI/LO visible exactly N cycles after the accepting edge; busy high for those N cycles.
- Results:
  - mult: signed full product, HI = upper WIDTH bits, LO = lower WIDTH bits.
  - multu: unsigned full product.
  - madd/maddu: {hi,lo} + product, signed/unsigned product, modulo 2^(2*WIDTH).
  - msub/msubu: {hi,lo} - product, modulo 2^(2*WIDTH).
  - The accumulate base is {hi,lo} at the accept edge.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide overflow: rs=0x80000000, rt=0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero: pending = current {hi,lo}, so HI/LO are unchanged; busy still runs DIV_CYCLES.
- mthi/mtlo: write hi/lo from rs_val at the next edge, only when busy=0; ignored when busy=1. The pipeline guarantees this via stall_d.
- mfhi/mflo: md_rdata reflects the registered hi/lo combinationally.
- stall_d = usemd(instr_d) and (busy or start_e).
  - usemd covers all twelve ops above; the accumulate ops count only if MACC_EN=1.
  - instr_d has no valid qualifier; a bubble is encoded as 0x00000000 (sll), which does not match.
- Start while busy=1 cannot occur because of stall_d; if it does, start_e is ignored and the counter is not reloaded.
- Reset, asserted asynchronously at any time including mid-operation:
  - cnt=0, busy=0, hi=0, lo=0, pending=0, stall_d follows combinationally.
  - Any in-flight result is discarded.
- No flush of an accepted operation: once accepted, it completes.

Decomposition:
- Shared head include:
  - op/funct constants (`special, `special2, mfhi_funct..divu_funct, madd_funct..msubu_funct).
  - md_* op-code encodings, extended with md_madd, md_maddu, md_msub, md_msubu (3-bit mdop).
- One sub-module, md_decode: combinational; instr in; mdop, start, usemd, is_mthi, is_mtlo, is_mfhi, is_mflo out.
  - Instantiated twice: E stage and D stage.
- Arithmetic and counter stay in the top.

Test Plan:
- mult rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; mflo in D during busy -> stall_d=1 each cycle, released when busy falls.
- divu rs=100, rt=7 -> after 10 cycles lo=14, hi=2; div rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div rs=5, rt=0 with hi=0x11, lo=0x22 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi rs=0x1234, mtlo rs=0x5678, then madd rs=2, rt=3 -> hi=0x1234, lo=0x567E after 5 cycles; msubu rs=1, rt=0x567F -> {hi,lo}=0x00001233_FFFFFFFF.
- Reset driven low 2 cycles into an 8-cycle-remaining div -> immediate busy=0, hi=lo=0, stall_d=0; after release no late HI/LO write.
- MACC_EN=0 build: madd with valid_e=1 -> busy stays 0, HI/LO unchanged, stall_d=0 for madd in D; valid_e=0 with mult in E -> no start.
